dcache_nway: RTL
================

Name: dcache_nway

Overview:
- Parametrised successor data cache: N-way set-associative, write-back, write-allocate, with a configurable number of sets and words per block.
- Sits between the datapath's dmem port and one coherence/memory-arbiter data port.
- On halt, writes back only the dirty lines, then optionally writes hit/miss statistics, then raises flushed.

Parameters:
SETS, 8, number of sets; power of 2, 2..64
WAYS, 2, associativity; 1, 2 or 4
BLOCK_WORDS, 2, 32-bit words per block; 1, 2, 4 or 8
STATS_ADDR, 32'h3100, word address for the statistics write-out

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
dmemREN  in  1  datapath read request
dmemWEN  in  1  datapath write request (never asserted with dmemREN)
dmemaddr  in  32  datapath byte address, word aligned
dmemstore  in  32  datapath write data
halt  in  1  begin flush; level, held until flushed
dhit  out  1  request completes this cycle
dmemload  out  32  read data, valid when dhit
flushed  out  1  flush complete
mem_ren  out  1  memory read request
mem_wen  out  1  memory write request
mem_addr  out  32  memory word address
mem_store  out  32  memory write data
mem_load  in  32  memory read data
mem_wait  in  1  memory busy; a transfer completes on a cycle with a request and mem_wait=0

Behaviour:
- Address split: [1:0] ignored; offset = next log2(BLOCK_WORDS) bits; index = next log2(SETS) bits; tag = remaining upper bits.
- Per line: valid, dirty, tag, BLOCK_WORDS data words. Per set: victim pointer of log2(WAYS) bits; width 0 when WAYS=1.
- Reset: state=IDLE; all valid/dirty/pointers cleared; counters=0; dhit, mem_ren, mem_wen, flushed=0; mem_addr, mem_store=0; dmemload=32'hBAD0BAD0. Applies from any state, including mid-transfer; the in-progress line is left invalid.
- States: IDLE, WB, FETCH, FLUSH_SCAN, FLUSH_WB, STATS, DONE.
- IDLE, hit (tag match and valid in any way, plus REN or WEN): dhit=1 combinationally in the same cycle. dmemload = matched word.
  - On write, the word is written and dirty set at the clock edge.
  - Hit count increments once per cycle that dhit=1.
- IDLE, miss: choose the victim as the lowest-index invalid way, else the set's victim pointer. Miss count increments by 1.
  - Victim valid and dirty -> WB; otherwise -> FETCH.
- WB: a word counter runs 0..BLOCK_WORDS-1.
  - mem_wen=1; mem_addr = {victim tag, index, word, 2'b00}; mem_store = victim word.
  - The counter advances when mem_wait=0. After the last word -> FETCH.
- FETCH: mem_ren=1; mem_addr = {req tag, index, word, 2'b00}.
  - On mem_wait=0, mem_load is written into the victim word.
  - On the last word: tag written, valid=1, dirty=0, victim pointer += 1 (mod WAYS), -> IDLE.
  - The request then hits in IDLE one cycle later. A write miss is completed by that hit.
- dhit=0 in every state except IDLE. The request must be held stable by the datapath until dhit.
- halt is sampled only in IDLE and takes priority over a pending request. Transition: -> FLUSH_SCAN with the scan pointer (set, way) = 0.
- FLUSH_SCAN: one cycle per line.
  - Valid and dirty -> FLUSH_WB (same addressing as WB). On completion, clear dirty and return to FLUSH_SCAN.
  - Otherwise advance the pointer: way first, then set.
  - After the last line (SETS-1, WAYS-1) -> STATS or DONE.
- Clean or invalid lines generate no memory traffic.
- DONE: flushed=1, held until RST. No memory requests. Requests are ignored (dhit=0).
- Counters are 32-bit, saturating at 32'hFFFFFFFF.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: STATS state issues two writes. First mem_addr=STATS_ADDR, mem_store=hit count. Then STATS_ADDR+4, miss count. Each completes on mem_wait=0. Then -> DONE.
- Undefined: counters and the STATS state are absent; the last FLUSH_SCAN line goes directly to DONE.

Test Plan:
(defaults SETS=8, WAYS=2, BLOCK_WORDS=2, mem_wait=0 unless stated)
1. Cold read 0x100; mem_load 0xAAAA0000 then 0xAAAA0001.
   -> mem_ren at addrs 0x100, 0x104; next IDLE cycle dhit=1, dmemload=0xAAAA0000; no mem_wen.
2. After test 1, write 0x104 = 0xDEADBEEF.
   -> dhit=1 same cycle; read 0x104 returns 0xDEADBEEF; halt -> writes 0x100=0xAAAA0000, 0x104=0xDEADBEEF only.
3. Fill 0x000 and 0x040, write 0x000 = 0x11111111, then read 0x080.
   -> way0 evicted: WB writes 0x000=0x11111111 and 0x004, then fetches 0x080/0x084; victim pointer=1.
4. mem_wait held 1 for 5 cycles during FETCH word 0.
   -> mem_addr and mem_ren stable; counter holds; no line update until mem_wait=0.
5. Halt with 3 clean lines and 1 dirty line (stats on; 5 hits, 4 misses).
   -> exactly 2 data writes, then 0x3100=5, 0x3104=4, then flushed=1 held.
6. RST=1 for one cycle during FETCH word 1.
   -> next cycle mem_ren=0, state IDLE; reread of the same address misses and refetches both words.

Source files
------------

// File: rtl/dcache_nway.sv
// dcache_nway: N-way set-associative, write-back, write-allocate data cache.
// On halt, dirty lines are written back, then optional statistics, then flushed rises.
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters and the STATS write-out).
module dcache_nway #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter logic [31:0] STATS_ADDR  = 32'h3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store,
  input  logic [31:0] mem_load,
  input  logic        mem_wait
);
  localparam int unsigned OFFB = $clog2(BLOCK_WORDS);
  localparam int unsigned IDXB = $clog2(SETS);
  localparam int unsigned TAGW = 30 - OFFB - IDXB;
  localparam int unsigned OW   = (OFFB > 0) ? OFFB : 1;
  localparam int unsigned IW   = IDXB;
  localparam int unsigned WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    StIdle, StWb, StFetch, StFlushScan, StFlushWb,
`ifdef DCACHE_STATS_EN
    StStats,
`endif
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   vic_q, vic_d;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   sset_q, sset_d;
  logic [WW-1:0]   sway_q, sway_d;
`ifdef DCACHE_STATS_EN
  logic            stat_q, stat_d;
  logic [31:0]     hits_q, hits_d, miss_q, miss_d;
`endif

  logic [31:0]     data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [TAGW-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WW-1:0]   ptr_q   [SETS];

  logic [OW-1:0]   req_off;
  logic [IW-1:0]   req_idx;
  logic [TAGW-1:0] req_tag;
  logic            hit, inv_found;
  logic [WW-1:0]   hit_way, inv_way, victim;
  logic            hit_we, miss_go, fill_we, fill_last, fwb_done;

  function automatic logic [31:0] line_addr(input logic [TAGW-1:0] t, input logic [IW-1:0] i,
                                            input logic [OW-1:0] w);
    return (32'(t) << (2 + OFFB + IDXB)) | (32'(i) << (2 + OFFB)) | (32'(w) << 2);
  endfunction

  assign req_off = OW'((dmemaddr >> 2) & 32'(BLOCK_WORDS - 1));
  assign req_idx = IW'(dmemaddr >> (2 + OFFB));
  assign req_tag = TAGW'(dmemaddr >> (2 + OFFB + IDXB));

  // Tag lookup and victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim = inv_found ? inv_way : ptr_q[req_idx];
  end

  assign dmemload = dhit ? data_q[req_idx][hit_way][req_off] : 32'hBAD0BAD0;

  // Next-state, memory-port outputs and storage write strobes.
  always_comb begin
    state_d   = state_q;
    vic_d     = vic_q;
    cnt_d     = cnt_q;
    sset_d    = sset_q;
    sway_d    = sway_q;
    dhit      = 1'b0;
    flushed   = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_store = '0;
    hit_we    = 1'b0;
    miss_go   = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    fwb_done  = 1'b0;
`ifdef DCACHE_STATS_EN
    stat_d    = stat_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StFlushScan;
          sset_d  = '0;
          sway_d  = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit) begin
            dhit   = 1'b1;
            hit_we = dmemWEN;
          end else begin
            miss_go = 1'b1;
            vic_d   = victim;
            cnt_d   = '0;
            state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? StWb : StFetch;
          end
        end
      end
      StWb: begin
        mem_wen   = 1'b1;
        mem_addr  = line_addr(tag_q[req_idx][vic_q], req_idx, cnt_q);
        mem_store = data_q[req_idx][vic_q][cnt_q];
        if (!mem_wait) begin
          if (cnt_q == OW'(BLOCK_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = StFetch;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFetch: begin
        mem_ren  = 1'b1;
        mem_addr = line_addr(req_tag, req_idx, cnt_q);
        if (!mem_wait) begin
          fill_we = 1'b1;
          if (cnt_q == OW'(BLOCK_WORDS - 1)) begin
            fill_last = 1'b1;
            cnt_d     = '0;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlushScan: begin
        if (valid_q[sset_q][sway_q] && dirty_q[sset_q][sway_q]) begin
          cnt_d   = '0;
          state_d = StFlushWb;
        end else if (sset_q == IW'(SETS - 1) && sway_q == WW'(WAYS - 1)) begin
`ifdef DCACHE_STATS_EN
          stat_d  = 1'b0;
          state_d = StStats;
`else
          state_d = StDone;
`endif
        end else if (sway_q == WW'(WAYS - 1)) begin
          sway_d = '0;
          sset_d = sset_q + 1'b1;
        end else begin
          sway_d = sway_q + 1'b1;
        end
      end
      StFlushWb: begin
        mem_wen   = 1'b1;
        mem_addr  = line_addr(tag_q[sset_q][sway_q], sset_q, cnt_q);
        mem_store = data_q[sset_q][sway_q][cnt_q];
        if (!mem_wait) begin
          if (cnt_q == OW'(BLOCK_WORDS - 1)) begin
            fwb_done = 1'b1;
            cnt_d    = '0;
            state_d  = StFlushScan;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef DCACHE_STATS_EN
      StStats: begin
        mem_wen   = 1'b1;
        mem_addr  = stat_q ? STATS_ADDR + 32'd4 : STATS_ADDR;
        mem_store = stat_q ? miss_q : hits_q;
        if (!mem_wait) begin
          if (stat_q) state_d = StDone;
          else        stat_d  = 1'b1;
        end
      end
`endif
      StDone:  flushed = 1'b1;
      default: state_d = StIdle;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters.
  always_comb begin
    hits_d = (dhit && hits_q != '1) ? hits_q + 32'd1 : hits_q;
    miss_d = (miss_go && miss_q != '1) ? miss_q + 32'd1 : miss_q;
  end
`endif

  // Control state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      vic_q   <= '0;
      cnt_q   <= '0;
      sset_q  <= '0;
      sway_q  <= '0;
`ifdef DCACHE_STATS_EN
      stat_q  <= 1'b0;
      hits_q  <= '0;
      miss_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
      cnt_q   <= cnt_d;
      sset_q  <= sset_d;
      sway_q  <= sway_d;
`ifdef DCACHE_STATS_EN
      stat_q  <= stat_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
`endif
    end
  end

  // Line storage; the victim is invalidated at miss start so an aborted refill stays invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      if (hit_we) begin
        data_q[req_idx][hit_way][req_off] <= dmemstore;
        dirty_q[req_idx][hit_way]         <= 1'b1;
      end
      if (miss_go) valid_q[req_idx][vic_d] <= 1'b0;
      if (fill_we) data_q[req_idx][vic_q][cnt_q] <= mem_load;
      if (fill_last) begin
        tag_q[req_idx][vic_q]   <= req_tag;
        valid_q[req_idx][vic_q] <= 1'b1;
        dirty_q[req_idx][vic_q] <= 1'b0;
        ptr_q[req_idx]          <= (WAYS > 1) ? ptr_q[req_idx] + 1'b1 : '0;
      end
      if (fwb_done) dirty_q[sset_q][sway_q] <= 1'b0;
    end
  end
endmodule
